audio_decim: RTL

Audio-rate decimation stage directly downstream of the 128-sample DC-removal averager in the FM demodulator chain. It consumes the DC-free demodulated samples on the same qualified strobe the averager uses. It reduces the rate by DECIM with a boxcar (sum-and-shift) filter. Decimated samples are buffered in a first-word-fall-through FIFO and presented on a valid/ready interface to the audio sink (DAC/serializer).

---
 rtl/audio_decim.sv | 134 +++++++++++++
 1 files changed

// File: rtl/audio_decim.sv
// Boxcar decimator (sum-and-shift) feeding a first-word-fall-through output FIFO.
// Define AUDIO_DECIM_ROUND_EN for round-half-up with saturation instead of a floor shift.
module audio_decim #(
  parameter int WIDTH      = 16,
  parameter int DECIM      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          sample_valid_i,
  input  logic signed [WIDTH-1:0]       data_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic signed [WIDTH-1:0]       data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o,
  output logic                          overflow_o
);

  localparam int SH = $clog2(DECIM);
  localparam int AW = WIDTH + SH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = PW + 1;

  logic signed [AW-1:0]    acc;
  logic [SH-1:0]           cnt;
  logic signed [AW-1:0]    sum;
  logic signed [WIDTH-1:0] dec;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  logic take;
  logic last;
  logic full;
  logic pop;
  logic push;
  logic do_push;

  assign take    = start_i & sample_valid_i;
  assign last    = (cnt == SH'(DECIM - 1));
  assign full    = (fill_o == FW'(FIFO_DEPTH));
  assign valid_o = (fill_o != '0);
  assign pop     = valid_o & ready_i;
  assign push    = take & last;
  assign do_push = push & (~full | pop);

`ifdef AUDIO_DECIM_ROUND_EN
  localparam logic signed [AW:0] MAXV =
    $signed({{(SH+2){1'b0}}, {(WIDTH-1){1'b1}}});
  localparam logic signed [AW:0] MINV =
    $signed({{(SH+2){1'b1}}, {(WIDTH-1){1'b0}}});

  logic signed [AW:0] wide;
  logic signed [AW:0] rsh;

  // Block sum, then round half up and clamp to the sample range
  always_comb begin
    sum  = acc + AW'(data_i);
    wide = $signed({sum[AW-1], sum}) + $signed((AW+1)'(DECIM / 2));
    rsh  = wide >>> SH;
    if (rsh > MAXV)
      dec = MAXV[WIDTH-1:0];
    else if (rsh < MINV)
      dec = MINV[WIDTH-1:0];
    else
      dec = rsh[WIDTH-1:0];
  end
`else
  // Block sum, then floor divide; the mean always fits in WIDTH
  always_comb begin
    sum = acc + AW'(data_i);
    dec = WIDTH'(sum >>> SH);
  end
`endif

  // Accumulate takes; a completed block restarts the phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (!start_i) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_valid_i) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Storage array; written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr] <= dec;
  end

  // Pointers, occupancy, sticky overflow and registered head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fill_o     <= '0;
      overflow_o <= 1'b0;
      data_o     <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (push & full & ~pop)
        overflow_o <= 1'b1;
      case ({do_push, pop})
        2'b10:   fill_o <= fill_o + 1'b1;
        2'b01:   fill_o <= fill_o - 1'b1;
        default: fill_o <= fill_o;
      endcase
      if (pop) begin
        if (fill_o > FW'(1))
          data_o <= mem[rptr + 1'b1];
        else if (do_push)
          data_o <= dec;
      end else if (!valid_o && do_push) begin
        data_o <= dec;
      end
    end
  end

endmodule
